// File: rtl/mips_pkg.sv
// Shared MIPS core types: fetch FSM states, IF/ID bundle, reset PC.
// Also carries add4, the PC incrementer reused across stages.
package mips_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  function automatic logic [31:0] add4(
    input logic [31:0] a
  );
    return a + 32'd4;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load, bubble or hold each cycle.
// A bubble leaves pc_plus4 untouched so redirect targets stay stable.
module if_id_reg
  import mips_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   load,
  input  logic   bubble,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q <= '0;
    end else if (bubble) begin
      q.instr <= NOP_INSTR;
      q.valid <= 1'b0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, imem req/ack port, IF/ID register.
// Define IF_JUMP_EN to add the JumpD port and internal J/JAL target.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        StallD,
  input  logic        PCSrcD,
  input  logic [31:0] PCBranchD,
`ifdef IF_JUMP_EN
  input  logic        JumpD,
`endif
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  fetch_state_t state;

  logic [31:0] pcf_q;
  logic [31:0] pcf_plus4;
  logic [31:0] hold_instr;
  logic [31:0] hold_pc4;
  logic [31:0] redir_pc;

  logic        jump_d;
  logic [31:0] raw_tgt;
  logic [31:0] target;
  logic        redirect;

  if_id_t id_d;
  if_id_t id_q;
  logic   id_load;
  logic   id_bubble;

`ifdef IF_JUMP_EN
  assign jump_d  = JumpD;
  assign raw_tgt = PCSrcD ? PCBranchD
                 : {id_q.pc_plus4[31:28],
                    id_q.instr[25:0], 2'b00};
`else
  assign jump_d  = 1'b0;
  assign raw_tgt = PCBranchD;
`endif

  assign target    = raw_tgt & ~32'h3;
  assign redirect  = (PCSrcD | jump_d)
                   & id_q.valid & ~StallD;
  assign pcf_plus4 = add4(pcf_q);

  assign imem_req  = reset_n & (state != HOLD);
  assign imem_addr = pcf_q;
  assign PCF       = pcf_q;

  assign InstrD    = id_q.instr;
  assign PCPlus4D  = id_q.pc_plus4;
  assign ValidD    = id_q.valid;

  always_comb begin
    id_load   = 1'b0;
    id_bubble = 1'b0;
    id_d      = '{instr:    imem_rdata,
                  pc_plus4: pcf_plus4,
                  valid:    1'b1};
    unique case (state)
      FETCH: begin
        if (redirect) begin
          id_bubble = 1'b1;
        end else if (!StallD) begin
          id_load   = imem_ack;
          id_bubble = ~imem_ack;
        end
      end
      HOLD: begin
        if (redirect) begin
          id_bubble = 1'b1;
        end else if (!StallD) begin
          id_load = 1'b1;
          id_d    = '{instr:    hold_instr,
                      pc_plus4: hold_pc4,
                      valid:    1'b1};
        end
      end
      DRAIN: id_bubble = 1'b1;
      default: id_bubble = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= FETCH;
      pcf_q      <= RESET_PC;
      hold_instr <= '0;
      hold_pc4   <= '0;
      redir_pc   <= '0;
    end else begin
      unique case (state)
        FETCH: begin
          if (imem_ack) begin
            if (redirect) begin
              pcf_q <= target;
            end else begin
              pcf_q <= pcf_plus4;
              if (StallD) begin
                hold_instr <= imem_rdata;
                hold_pc4   <= pcf_plus4;
                state      <= HOLD;
              end
            end
          end else if (redirect) begin
            redir_pc <= target;
            state    <= DRAIN;
          end
        end
        HOLD: begin
          if (redirect) begin
            pcf_q      <= target;
            hold_instr <= '0;
            hold_pc4   <= '0;
            state      <= FETCH;
          end else if (!StallD) begin
            state <= FETCH;
          end
        end
        DRAIN: begin
          // imem_addr stays on the old PC until its access retires
          if (imem_ack) begin
            pcf_q <= redirect ? target : redir_pc;
            state <= FETCH;
          end else if (redirect) begin
            redir_pc <= target;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  if_id_reg u_if_id (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (id_load),
    .bubble  (id_bubble),
    .d       (id_d),
    .q       (id_q)
  );

endmodule
